// File: rtl/register_arbiter.sv
// register_arbiter: round-robin front end that lets N_REQ requesters share one
// load/increment register. Each grant drives ld or inc for a single cycle,
// captures the register output and returns it with a one-cycle ack.
module register_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         op_inc,
  input  logic [N_REQ*WIDTH-1:0]   wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         ack,
  output logic [WIDTH-1:0]         rdata,
  output logic                     busy,
  output logic                     reg_ld,
  output logic                     reg_inc,
  output logic [WIDTH-1:0]         reg_in,
  input  logic [WIDTH-1:0]         reg_out
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, ISSUE, CAPTURE} state_t;

  state_t             state, state_nx;
  logic [PTR_W-1:0]   ptr, ptr_nx;
  logic [PTR_W-1:0]   win, win_nx;
  logic               op_q, op_nx;
  logic [WIDTH-1:0]   data_q, data_nx;
  logic [N_REQ-1:0]   gnt_nx, ack_nx;
  logic [WIDTH-1:0]   rdata_nx, in_nx;
  logic               busy_nx, ld_nx, inc_nx;

  logic [N_REQ-1:0]   elig;
  logic               found;
  logic [PTR_W-1:0]   pick;
  logic [WIDTH-1:0]   wdata_a [N_REQ];

  // Split the flat load-data bus into per-requester words.
  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      wdata_a[i] = wdata[i*WIDTH +: WIDTH];
    end
  end

  // Rotating search from ptr; a requester being acked this cycle is masked.
  always_comb begin
    elig  = req & ~ack;
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (!found && elig[PTR_W'((32'(ptr) + i) % N_REQ)]) begin
        found = 1'b1;
        pick  = PTR_W'((32'(ptr) + i) % N_REQ);
      end
    end
  end

  // Next-state and next-output logic; pins and ack default to idle values.
  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    win_nx   = win;
    op_nx    = op_q;
    data_nx  = data_q;
    gnt_nx   = gnt;
    ack_nx   = '0;
    rdata_nx = rdata;
    ld_nx    = 1'b0;
    inc_nx   = 1'b0;
    in_nx    = '0;
    case (state)
      IDLE: begin
        if (found) begin
          win_nx   = pick;
          op_nx    = op_inc[pick];
          data_nx  = wdata_a[pick];
          gnt_nx   = N_REQ'(1) << pick;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (op_q) begin
          inc_nx = 1'b1;
        end else begin
          ld_nx = 1'b1;
          in_nx = data_q;
        end
        state_nx = ISSUE;
      end
      ISSUE: begin
        state_nx = CAPTURE;
      end
      CAPTURE: begin
        rdata_nx = reg_out;
        ack_nx   = N_REQ'(1) << win;
        gnt_nx   = '0;
        ptr_nx   = (win == PTR_W'(N_REQ - 1)) ? '0 : win + PTR_W'(1);
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      win     <= '0;
      op_q    <= 1'b0;
      data_q  <= '0;
      gnt     <= '0;
      ack     <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      reg_ld  <= 1'b0;
      reg_inc <= 1'b0;
      reg_in  <= '0;
    end else begin
      state   <= state_nx;
      ptr     <= ptr_nx;
      win     <= win_nx;
      op_q    <= op_nx;
      data_q  <= data_nx;
      gnt     <= gnt_nx;
      ack     <= ack_nx;
      rdata   <= rdata_nx;
      busy    <= busy_nx;
      reg_ld  <= ld_nx;
      reg_inc <= inc_nx;
      reg_in  <= in_nx;
    end
  end

endmodule

// File: tb/tb_register_arbiter.sv
// Bench for register_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction model.
module tb_register_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk, rst;
  logic [N-1:0]   req, op_inc;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt, ack;
  logic [W-1:0]   rdata, reg_in, reg_out;
  logic           busy, reg_ld, reg_inc;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_ld   = 0;
  int n_inc  = 0;
  bit started = 0;

  register_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .op_inc(op_inc), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy),
    .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_in(reg_in), .reg_out(reg_out)
  );

  // Shared load/increment register; its reset follows rst.
  logic [W-1:0] reg_q;
  always_ff @(posedge clk) begin
    if (rst)          reg_q <= '0;
    else if (reg_ld)  reg_q <= reg_in;
    else if (reg_inc) reg_q <= reg_q + 8'd1;
  end
  assign reg_out = reg_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: each accepted request is a 4-edge transaction
  // measured from its grant edge (offset 1: pins, 2: register updates, 3: ack).
  logic [N-1:0] e_gnt, e_ack;
  logic [W-1:0] e_rdata, e_in, m_reg, m_data;
  logic         e_busy, e_ld, e_inc, m_op;
  int           m_ptr, m_win, t_since;

  task automatic model_step();
    logic [N-1:0] elig;
    if (rst) begin
      t_since = 0; m_ptr = 0; m_win = 0; m_reg = '0; m_op = 1'b0; m_data = '0;
      e_gnt = '0; e_ack = '0; e_rdata = '0; e_busy = 1'b0;
      e_ld = 1'b0; e_inc = 1'b0; e_in = '0;
    end else begin
      elig  = req & ~e_ack;
      e_ack = '0;
      e_ld  = 1'b0;
      e_inc = 1'b0;
      e_in  = '0;
      if (t_since == 0) begin
        for (int j = 0; j < N; j++) begin
          int c;
          c = (m_ptr + j) % N;
          if (t_since == 0 && elig[c]) begin
            m_win   = c;
            m_op    = op_inc[c];
            m_data  = wdata[c*W +: W];
            e_gnt   = N'(1) << c;
            e_busy  = 1'b1;
            t_since = 1;
          end
        end
      end else if (t_since == 1) begin
        e_ld    = !m_op;
        e_inc   = m_op;
        e_in    = m_op ? 8'd0 : m_data;
        t_since = 2;
      end else if (t_since == 2) begin
        m_reg   = m_op ? m_reg + 8'd1 : m_data;
        t_since = 3;
      end else begin
        e_rdata = m_reg;
        e_ack   = N'(1) << m_win;
        e_gnt   = '0;
        e_busy  = 1'b0;
        m_ptr   = (m_win + 1) % N;
        t_since = 0;
      end
    end
  endtask

  // Advance the model on every active edge.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      started = 1;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        chk("m_gnt",   32'(gnt),     32'(e_gnt));
        chk("m_ack",   32'(ack),     32'(e_ack));
        chk("m_rdata", 32'(rdata),   32'(e_rdata));
        chk("m_busy",  32'(busy),    32'(e_busy));
        chk("m_ld",    32'(reg_ld),  32'(e_ld));
        chk("m_inc",   32'(reg_inc), 32'(e_inc));
        chk("m_in",    32'(reg_in),  32'(e_in));
        chk("ld_inc_excl", 32'(reg_ld & reg_inc), 32'd0);
        if (reg_ld)  n_ld++;
        if (reg_inc) n_inc++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_ack(output logic [N-1:0] a);
    bit got;
    got = 0;
    a   = '0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        got = 1;
        a   = ack;
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL ack_wait: no ack within 40 cycles (t=%0t)", $time);
    end
  endtask

  task automatic do_txn(input int i, input logic op, input logic [W-1:0] d,
                        output logic [N-1:0] a, output logic [W-1:0] rd);
    req[i]          = 1'b1;
    op_inc[i]       = op;
    wdata[i*W +: W] = d;
    wait_ack(a);
    rd     = rdata;
    req[i] = 1'b0;
    tick();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  initial begin
    logic [N-1:0] a;
    logic [W-1:0] rd;
    int l0, i0, last_cyc, idx;
    int rr_exp [5];
    rr_exp = '{0, 1, 2, 3, 0};

    rst = 1'b1; req = '1; op_inc = '0; wdata = '0;

    // Reset held with all requests asserted.
    repeat (2) begin
      tick();
      chk("rst_gnt",   32'(gnt),   32'd0);
      chk("rst_ack",   32'(ack),   32'd0);
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_pins",  32'({reg_ld, reg_inc}), 32'd0);
      chk("rst_rdata", 32'(rdata), 32'd0);
    end
    rst = 1'b0; req = '0;
    tick();

    // Single load by requester 2.
    req[2] = 1'b1; op_inc[2] = 1'b0; wdata[2*W +: W] = 8'hA5;
    tick(); chk("sl_gnt", 32'(gnt), 32'h4); chk("sl_busy", 32'(busy), 32'd1);
    tick(); chk("sl_ld", 32'(reg_ld), 32'd1); chk("sl_in", 32'(reg_in), 32'hA5);
    tick(); chk("sl_ld_off", 32'(reg_ld), 32'd0); chk("sl_noack", 32'(ack), 32'd0);
    tick(); chk("sl_ack", 32'(ack), 32'h4); chk("sl_rdata", 32'(rdata), 32'hA5);
    chk("sl_busy_off", 32'(busy), 32'd0);
    req[2] = 1'b0;
    tick(); chk("sl_ack_off", 32'(ack), 32'd0); chk("sl_hold", 32'(rdata), 32'hA5);

    // Increment wrap through requester 0.
    do_txn(0, 1'b0, 8'hFF, a, rd);
    chk("wr_ack1", 32'(a), 32'h1); chk("wr_rd1", 32'(rd), 32'hFF);
    l0 = n_ld; i0 = n_inc;
    do_txn(0, 1'b1, 8'h3C, a, rd);
    chk("wr_ack2", 32'(a), 32'h1); chk("wr_rd2", 32'(rd), 32'h00);
    chk("wr_inc_pulses", 32'(n_inc - i0), 32'd1);
    chk("wr_ld_pulses",  32'(n_ld - l0),  32'd0);

    // Round robin with every requester holding a load.
    pulse_reset();
    for (int i = 0; i < N; i++) begin
      op_inc[i] = 1'b0; wdata[i*W +: W] = 8'(8'h10 + i);
    end
    req = '1;
    last_cyc = 0;
    for (int t = 0; t < 5; t++) begin
      wait_ack(a);
      idx = oh2i(a);
      chk("rr_order", 32'(idx), 32'(rr_exp[t]));
      chk("rr_rdata", 32'(rdata), 32'(8'h10 + rr_exp[t]));
      if (t > 0) chk("rr_spacing", 32'(cyc - last_cyc), 32'd4);
      last_cyc = cyc;
    end
    req = '0;
    repeat (2) tick();

    // Held request is masked on its ack cycle.
    pulse_reset();
    wdata[1*W +: W] = 8'h21; wdata[3*W +: W] = 8'h23;
    req = 4'b1010;
    wait_ack(a);
    chk("hm_first", 32'(a), 32'h2); chk("hm_rd1", 32'(rdata), 32'h21);
    chk("hm_gnt_ackcyc", 32'(gnt), 32'd0);
    wait_ack(a);
    chk("hm_second", 32'(a), 32'h8); chk("hm_rd3", 32'(rdata), 32'h23);
    req[3] = 1'b0;
    tick(); chk("hm_regrant", 32'(gnt), 32'h2);
    wait_ack(a);
    chk("hm_third", 32'(a), 32'h2);
    tick(); chk("hm_masked", 32'(gnt), 32'd0);
    tick(); chk("hm_after_mask", 32'(gnt), 32'h2);
    req = '0;
    wait_ack(a);
    tick();

    // Reset during the issue cycle of a requester-0 load.
    req[0] = 1'b1; op_inc[0] = 1'b0; wdata[0 +: W] = 8'h55;
    tick(); chk("mr_gnt", 32'(gnt), 32'h1);
    tick(); chk("mr_ld", 32'(reg_ld), 32'd1);
    rst = 1'b1; req = '0;
    tick();
    chk("mr_ack", 32'(ack), 32'd0); chk("mr_gnt0", 32'(gnt), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0); chk("mr_ld0", 32'(reg_ld), 32'd0);
    rst = 1'b0;
    repeat (4) begin tick(); chk("mr_noack", 32'(ack), 32'd0); end
    op_inc[3] = 1'b0; wdata[3*W +: W] = 8'h77;
    req = 4'b1001;
    wait_ack(a);
    chk("mr_ptr0_win", 32'(a), 32'h1); chk("mr_rd0", 32'(rdata), 32'h55);
    req[0] = 1'b0;
    wait_ack(a);
    chk("mr_next", 32'(a), 32'h8); chk("mr_rd3", 32'(rdata), 32'h77);
    req = '0;
    tick();

    // Randomized traffic, including late op/data changes and rare resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      rst = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            req[i] = 1'b1; op_inc[i] = 1'($urandom_range(0, 1));
            wdata[i*W +: W] = 8'($urandom);
          end else begin
            req[i] = 1'b0;
          end
        end else if (!req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req[i] = 1'b1; op_inc[i] = 1'($urandom_range(0, 1));
            wdata[i*W +: W] = 8'($urandom);
          end
        end else if (gnt[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            op_inc[i] = ~op_inc[i]; wdata[i*W +: W] = 8'($urandom);
          end
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end
      end
    end
    rst = 1'b0; req = '0;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/register_arbiter.md
# register_arbiter

Round-robin arbiter and sequencer that shares the 8-bit load/increment register between N requesters. Each requester posts a load or an increment through a req/ack handshake. The arbiter drives the register's ld/inc/in pins for one cycle, captures the register's output, and returns it to the winning requester. It sits directly in front of the register instance. The register's active-low reset is driven from ~rst at integration.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, register/data width
- clk  input  1  rising-edge clock, shared with the register
- rst  input  1  synchronous, active-high reset
- req  input  N_REQ  per-requester request level; hold until own ack
- op_inc  input  N_REQ  per-requester op select: 1 = increment, 0 = load; sampled with req
- wdata  input  N_REQ*WIDTH  per-requester load value; slice i = [i*WIDTH +: WIDTH]; ignored for increment
- gnt  output  N_REQ  one-hot grant, high for the whole transaction
- ack  output  N_REQ  one-cycle completion pulse to the winner
- rdata  output  WIDTH  register value after the winner's op; valid while ack is high, held until the next capture
- busy  output  1  high in every state except IDLE
- reg_ld  output  1  to register ld
- reg_inc  output  1  to register inc
- reg_in  output  WIDTH  to register in
- reg_out  input  WIDTH  from register out

## Operation
- All outputs are registered.
- FSM states: IDLE, GRANT, ISSUE, CAPTURE.
- Round-robin pointer `ptr` (log2 N_REQ bits) marks the highest-priority index. Search order is ptr, ptr+1, … wrapping mod N_REQ.
- **IDLE**
  - Eligible set = req & ~ack. A requester whose ack is high this cycle is masked, so a held-over req is not re-granted.
  - If the eligible set is non-empty: latch winner index, op_inc[winner] and wdata slice; set gnt to one-hot(winner); go to GRANT.
- **GRANT**
  - Load op: reg_ld<=1, reg_inc<=0, reg_in<=latched data.
  - Increment op: reg_inc<=1, reg_ld<=0, reg_in<=0.
  - Go to ISSUE.
- **ISSUE**
  - reg_ld, reg_inc and reg_in all cleared to 0. The register updates on this edge.
  - Go to CAPTURE.
- **CAPTURE**
  - rdata<=reg_out; ack[winner]<=1; gnt<=0; ptr<=(winner+1) mod N_REQ.
  - Go to IDLE.
- ack is cleared on the following edge regardless of state.
- reg_ld and reg_inc are never high together and never high outside the single ISSUE cycle.
- Request changes after latching do not affect the transaction in flight: req dropped, or op_inc/wdata changed, after GRANT.
- Wrap-around: increment of all-ones returns 0 (register's native modulo-2^WIDTH behaviour); rdata reflects that.
- Simultaneous requests: exactly one grant. The others stay pending and are served in rotating order, so there is no starvation. Worst-case wait is (N_REQ−1) transactions.

## Timing
- **Reset** (rst sampled high at an edge):
  - state=IDLE, ptr=0.
  - gnt, ack, rdata, reg_ld, reg_inc, reg_in, busy = 0.
- **Reset mid-transaction** (any state): the transaction is abandoned, no ack is issued, and the outputs go to reset values at that edge. The register is cleared by the same reset.
- **Latency**, with req seen in IDLE at edge k:
  - gnt and busy high after k.
  - reg_ld/reg_inc high during cycle k+1→k+2.
  - Register updates at k+2.
  - ack and rdata valid during cycle k+3→k+4.
  - IDLE is re-entered at k+3; the next grant is at edge k+4 at the earliest.
- **Throughput**: one operation per 4 cycles under continuous requests.
- busy falls at edge k+3, coincident with ack rising.
- **Requester rule**: drop req, or present a new op, no later than the cycle after ack. The ack mask covers the ack cycle only.

## Test plan
- **Reset:** drive rst=1 for 2 cycles with req=4'b1111 → gnt=0, ack=0, reg_ld=reg_inc=0, rdata=0, busy=0 throughout.
- **Single load:** requester 2 loads 0xA5 from idle → gnt=4'b0100 one edge later; reg_ld for exactly 1 cycle with reg_in=0xA5; ack=4'b0100 for 1 cycle 3 edges after gnt; rdata=0xA5.
- **Increment wrap:** load 0xFF via requester 0, then increment via requester 0 → second ack with rdata=0x00; reg_inc pulses once, reg_ld stays 0.
- **Round robin:** all four requesters hold req (loads of 0x10, 0x11, 0x12, 0x13 for requesters 0..3), re-asserting after each ack → grant order 0,1,2,3,0; each rdata matches its requester's value; 4 cycles between successive acks.
- **Held request / masking:** requester 1 keeps req high through and after its ack while requester 3 also requests → next grant goes to 3, not 1; requester 1 is not granted on the ack cycle.
- **Reset mid-op:** assert rst during ISSUE of a requester-0 load of 0x55 → no ack; after release, ptr=0; the next request from requester 0 completes normally with its own value.
